pc_unit: RTL and testbench

Program-counter and fetch-sequencing stage that sits directly upstream of `control_logic`. It holds the PC, drives the instruction-ROM address, and runs the start/run/halt state machine. It computes the next PC from the decoded `reg_OP` that `control_logic` returns for the current instruction, covering jumps, branches, lookup jumps, calls and returns, and it owns a small hardware return stack.

---
 rtl/pc_unit_pkg.sv | 19 +
 rtl/pc_unit_return_stack.sv | 41 ++++
 rtl/pc_unit.sv | 104 ++++++++++
 tb/tb_pc_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared types for the fetch stage: decoded op codes, sequencer states and
// default lookup-jump targets.
package pc_unit_pkg;

    typedef enum logic [3:0] {
        opNop, opAlu, opLd, opSt,
        jizrEn, jnzrEn, bizrEn, bnzrEn,
        ljp0, ljp1, ljp2, ljp3,
        j2sr, funcEn, rFsr
    } reg_OP;

    typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state;

    localparam int LJP0_DEF = 0;
    localparam int LJP1_DEF = 64;
    localparam int LJP2_DEF = 128;
    localparam int LJP3_DEF = 192;

endpackage

// File: rtl/pc_unit_return_stack.sv
// LIFO of return addresses. The count doubles as the write pointer; the top of
// stack is the entry just below it.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-2:0] wptr, top;

    assign wptr  = cnt_q[CW-2:0];
    assign top   = wptr - 1'b1;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[top];

    always_comb begin
        cnt_d = cnt_q;
        if (clr)                cnt_d = '0;
        else if (push && !full) cnt_d = cnt_q + 1'b1;
        else if (pop && !empty) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
        if (!reset && !clr && push && !full) mem_q[wptr] <= din;
    end
endmodule

// File: rtl/pc_unit.sv
// Program counter and start/run/halt sequencer; picks the next fetch address
// from the decoded op of the instruction currently at pc.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                PC_W  = 10,
    parameter int                STK_D = 4,
    parameter logic [PC_W-1:0]   LJP0  = PC_W'(LJP0_DEF),
    parameter logic [PC_W-1:0]   LJP1  = PC_W'(LJP1_DEF),
    parameter logic [PC_W-1:0]   LJP2  = PC_W'(LJP2_DEF),
    parameter logic [PC_W-1:0]   LJP3  = PC_W'(LJP3_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            done,
    input  reg_OP           reg_op,
    input  logic [3:0]      imm,
    input  logic [7:0]      src_val,
    input  logic            zero,
    output logic [PC_W-1:0] pc,
    output logic            running,
    output logic            halted,
    output logic            stk_err
);
    pc_state         state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            err_q, err_d;
    logic            push, pop, clr, full, empty;
    logic [PC_W-1:0] pc_inc, off_imm, off_src, abs_src, stk_top;

    assign pc_inc  = pc_q + 1'b1;
    assign off_imm = pc_q + {{(PC_W-4){imm[3]}}, imm};
    assign off_src = pc_q + {{(PC_W-8){src_val[7]}}, src_val};
    assign abs_src = {{(PC_W-8){1'b0}}, src_val};

    return_stack #(.DEPTH(STK_D), .W(PC_W)) u_stk (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .clr(clr),
        .din(pc_inc), .dout(stk_top), .full(full), .empty(empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        clr     = 1'b0;
        // start rewinds from any state and outranks done
        if (start || state_q == IDLE) begin
            state_d = start ? IDLE : RUN;
            pc_d    = '0;
            err_d   = 1'b0;
            clr     = 1'b1;
        end else if (state_q == RUN) begin
            if (done) begin
                state_d = HALT;
            end else begin
                pc_d = pc_inc;
                case (reg_op)
                    jizrEn: if (zero)  pc_d = off_imm;
                    jnzrEn: if (!zero) pc_d = off_imm;
                    bizrEn: if (zero)  pc_d = off_src;
                    bnzrEn: if (!zero) pc_d = off_src;
                    ljp0:   pc_d = LJP0;
                    ljp1:   pc_d = LJP1;
                    ljp2:   pc_d = LJP2;
                    ljp3:   pc_d = LJP3;
                    j2sr:   pc_d = abs_src;
                    funcEn: begin
                        pc_d = abs_src;
                        if (full) err_d = 1'b1;
                        else      push  = 1'b1;
                    end
                    rFsr: begin
                        if (empty) err_d = 1'b1;
                        else begin
                            pop  = 1'b1;
                            pc_d = stk_top;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    assign pc      = pc_q;
    assign running = (state_q == RUN);
    assign halted  = (state_q == HALT);
    assign stk_err = err_q;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios with constant expectations plus a
// randomized run checked against a plain-arithmetic model of the sequencer.
module tb_pc_unit;
    import pc_unit_pkg::*;

    logic       clk = 0, reset = 1, start = 1, done = 0, zero = 0;
    reg_OP      reg_op = opNop;
    logic [3:0] imm = 0;
    logic [7:0] src_val = 0;
    logic [9:0] pc;
    logic       running, halted, stk_err;

    int errors = 0, checks = 0;

    // model: mode 0=idle 1=run 2=halt
    int m_pc = 0, m_mode = 0;
    bit m_err = 0;
    int m_stk[$];

    pc_unit dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .reg_op(reg_op),
        .imm(imm), .src_val(src_val), .zero(zero), .pc(pc), .running(running),
        .halted(halted), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int si, ss;
        si = (imm >= 8) ? int'(imm) - 16 : int'(imm);
        ss = (src_val >= 128) ? int'(src_val) - 256 : int'(src_val);
        if (reset || start || m_mode == 0) begin
            m_mode = (reset || start) ? 0 : 1;
            m_pc = 0; m_err = 0; m_stk.delete();
        end else if (m_mode == 1) begin
            if (done) m_mode = 2;
            else begin
                int nx;
                nx = m_pc + 1;
                case (reg_op)
                    jizrEn: if (zero)  nx = m_pc + si;
                    jnzrEn: if (!zero) nx = m_pc + si;
                    bizrEn: if (zero)  nx = m_pc + ss;
                    bnzrEn: if (!zero) nx = m_pc + ss;
                    ljp0: nx = 0;
                    ljp1: nx = 64;
                    ljp2: nx = 128;
                    ljp3: nx = 192;
                    j2sr: nx = src_val;
                    funcEn: begin
                        if (m_stk.size() >= 4) m_err = 1;
                        else m_stk.push_back((m_pc + 1) & 1023);
                        nx = src_val;
                    end
                    rFsr: begin
                        if (m_stk.size() == 0) m_err = 1;
                        else nx = m_stk.pop_back();
                    end
                    default: ;
                endcase
                m_pc = nx & 1023;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        reset = 1; start = 1; done = 0; reg_op = opNop;
        tick();
        reset = 0;
        tick();
        start = 0;
        tick();
    endtask

    task automatic adv(input int n);
        reg_op = opNop;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1; start = 1;
        tick(); tick();
        checks++; if ({pc, running, halted, stk_err} !== 13'd0) begin
            errors++; $display("FAIL reset_vals got pc=%0d r=%b h=%b e=%b want 0", pc, running, halted, stk_err);
        end
        reset = 0;
        tick();
        checks++; if (running !== 1'b0 || pc !== 10'd0) begin
            errors++; $display("FAIL idle_hold got r=%b pc=%0d want r=0 pc=0", running, pc);
        end
        start = 0;
        tick();
        checks++; if (running !== 1'b1 || pc !== 10'd0) begin
            errors++; $display("FAIL run_entry got r=%b pc=%0d want r=1 pc=0", running, pc);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (pc !== 10'(i)) begin
                errors++; $display("FAIL seq_pc got %0d want %0d", pc, i);
            end
        end
    endtask

    task automatic test_branches();
        restart(); adv(5);
        reg_op = jnzrEn; zero = 0; imm = 4'hE; tick();
        checks++; if (pc !== 10'd3) begin
            errors++; $display("FAIL jnz_taken got %0d want 3", pc);
        end
        restart(); adv(5);
        reg_op = jnzrEn; zero = 1; imm = 4'hE; tick();
        checks++; if (pc !== 10'd6) begin
            errors++; $display("FAIL jnz_not_taken got %0d want 6", pc);
        end
        restart();
        reg_op = bizrEn; zero = 1; src_val = 8'hFF; tick();
        checks++; if (pc !== 10'd1023) begin
            errors++; $display("FAIL biz_wrap got %0d want 1023", pc);
        end
        reg_op = opNop; tick();
        checks++; if (pc !== 10'd0) begin
            errors++; $display("FAIL inc_wrap got %0d want 0", pc);
        end
        reg_op = ljp3; tick();
        checks++; if (pc !== 10'd192) begin
            errors++; $display("FAIL ljp3 got %0d want 192", pc);
        end
    endtask

    task automatic test_calls();
        restart(); adv(10);
        reg_op = funcEn; src_val = 40; tick();
        checks++; if (pc !== 10'd40) begin
            errors++; $display("FAIL call_target got %0d want 40", pc);
        end
        adv(2);
        reg_op = rFsr; tick();
        checks++; if (pc !== 10'd11 || stk_err !== 1'b0) begin
            errors++; $display("FAIL return got pc=%0d err=%b want pc=11 err=0", pc, stk_err);
        end
        reg_op = funcEn; src_val = 100;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (stk_err !== 1'b0) begin
            errors++; $display("FAIL four_calls_err got %b want 0", stk_err);
        end
        tick();
        checks++; if (pc !== 10'd100 || stk_err !== 1'b1) begin
            errors++; $display("FAIL overflow got pc=%0d err=%b want pc=100 err=1", pc, stk_err);
        end
        reg_op = rFsr; tick();
        checks++; if (pc !== 10'd101 || stk_err !== 1'b1) begin
            errors++; $display("FAIL pop_after_ovf got pc=%0d err=%b want pc=101 err=1", pc, stk_err);
        end
    endtask

    task automatic test_underflow();
        restart(); adv(7);
        reg_op = rFsr; tick();
        checks++; if (pc !== 10'd8 || stk_err !== 1'b1) begin
            errors++; $display("FAIL underflow got pc=%0d err=%b want pc=8 err=1", pc, stk_err);
        end
        reg_op = opNop; start = 1; tick();
        checks++; if (pc !== 10'd0 || stk_err !== 1'b0 || running !== 1'b0) begin
            errors++; $display("FAIL rewind got pc=%0d err=%b r=%b want 0/0/0", pc, stk_err, running);
        end
        start = 0;
    endtask

    task automatic test_halt();
        restart(); adv(20);
        done = 1; reg_op = ljp2; tick();
        checks++; if (halted !== 1'b1 || running !== 1'b0 || pc !== 10'd20) begin
            errors++; $display("FAIL halt got h=%b r=%b pc=%0d want h=1 r=0 pc=20", halted, running, pc);
        end
        done = 0; tick();
        checks++; if (halted !== 1'b1 || pc !== 10'd20) begin
            errors++; $display("FAIL halt_hold got h=%b pc=%0d want h=1 pc=20", halted, pc);
        end
        start = 1; tick();
        checks++; if (halted !== 1'b0 || pc !== 10'd0) begin
            errors++; $display("FAIL halt_exit got h=%b pc=%0d want h=0 pc=0", halted, pc);
        end
        restart(); adv(3);
        done = 1; start = 1; tick();
        checks++; if (halted !== 1'b0 || running !== 1'b0 || pc !== 10'd0) begin
            errors++; $display("FAIL start_over_done got h=%b r=%b pc=%0d want 0/0/0", halted, running, pc);
        end
        done = 0; start = 0;
    endtask

    task automatic test_reset_mid();
        restart(); adv(6);
        reg_op = funcEn; src_val = 77; tick();
        reg_op = rFsr; tick(); tick();
        reset = 1; reg_op = ljp1; tick();
        checks++; if ({pc, running, halted, stk_err} !== 13'd0) begin
            errors++; $display("FAIL reset_mid got pc=%0d r=%b h=%b e=%b want 0", pc, running, halted, stk_err);
        end
        reset = 0; reg_op = opNop;
    endtask

    task automatic test_random();
        restart();
        for (int i = 0; i < 600; i++) begin
            reg_op  = reg_OP'($urandom_range(0, 14));
            imm     = 4'($urandom);
            src_val = 8'($urandom);
            zero    = 1'($urandom);
            done    = ($urandom_range(0, 39) == 0);
            start   = ($urandom_range(0, 59) == 0);
            reset   = ($urandom_range(0, 149) == 0);
            tick();
            checks++;
            if (pc !== 10'(m_pc) || running !== (m_mode == 1) || halted !== (m_mode == 2) || stk_err !== m_err) begin
                errors++;
                $display("FAIL rand_%0d got pc=%0d r=%b h=%b e=%b want pc=%0d mode=%0d e=%b",
                         i, pc, running, halted, stk_err, m_pc, m_mode, m_err);
            end
        end
        reset = 0; start = 0; done = 0;
    endtask

    initial begin
        test_reset();
        test_branches();
        test_calls();
        test_underflow();
        test_halt();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
